pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the payload width in bits.
REQ-002 Parameter DEPTH, default 2, legal values 1..16, SHALL set the number of storage entries; DEPTH need not be a power of two.
REQ-003 Parameter BUBBLE, default 32'h0000_0013, SHALL set the payload driven on out_data when no valid entry is presented.
REQ-004 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 Port flush  input  1  SHALL kill all stored entries (branch, interrupt or mret redirect).
REQ-007 Port in_valid  input  1  SHALL mark in_data as valid from the upstream stage.
REQ-008 Port in_data  input  WIDTH  SHALL be the upstream payload (instruction, PC or ALU result).
REQ-009 Port in_ready  output  1  SHALL indicate that a push is accepted this cycle.
REQ-010 Port out_valid  output  1  SHALL mark out_data as valid toward the downstream stage.
REQ-011 Port out_data  output  WIDTH  SHALL be the downstream payload.
REQ-012 Port out_ready  input  1  SHALL indicate that the downstream stage consumes out_data this cycle.
REQ-013 Port count  output  $clog2(DEPTH+1)  SHALL give the number of stored entries.

Function
REQ-014 A push SHALL occur when in_valid && in_ready && !flush; a pop SHALL occur when out_valid && out_ready && !flush.
REQ-015 in_ready SHALL equal (count != DEPTH) and SHALL NOT depend combinationally on out_ready.
REQ-016 Storage SHALL be a circular buffer with write and read pointers that wrap from DEPTH-1 to 0.
REQ-017 count SHALL increment on push-only, decrement on pop-only, and hold on simultaneous push and pop, including the full case (count == DEPTH) and the count == 1 case.
REQ-018 out_valid SHALL equal (count != 0); out_data SHALL be the entry at the read pointer when count != 0 and BUBBLE otherwise.
REQ-019 Latency SHALL be one cycle: data pushed in cycle N SHALL appear on out_data in cycle N+1 when the buffer was empty.
REQ-020 Entries SHALL leave in strict push order; no entry SHALL be duplicated or dropped except by flush or rst.
REQ-021 flush SHALL have priority over push and pop: in the next cycle count SHALL be 0, both pointers SHALL be 0, and out_valid SHALL be 0; a push presented in the flush cycle SHALL be discarded.
REQ-022 When DEPTH == 1, the block SHALL behave as a single flushable pipeline register; in_ready SHALL be 0 while it is occupied.
REQ-023 Storage contents SHALL NOT be cleared by flush or rst; only pointers and count SHALL be cleared.

Reset
REQ-024 While rst is high at a clock edge, count, the write pointer and the read pointer SHALL become 0.
REQ-025 After reset: out_valid = 0, out_data = BUBBLE, in_ready = 1.
REQ-026 rst asserted mid-stream SHALL discard all entries, and rst SHALL take priority over flush, push and pop.

Configuration
REQ-027 The macro PIPE_STAGE_BYPASS_EN SHALL control bypass.
REQ-028 With PIPE_STAGE_BYPASS_EN defined: when count == 0, in_valid == 1 and flush == 0, out_valid SHALL be 1 and out_data SHALL be in_data in the same cycle.
REQ-029 With PIPE_STAGE_BYPASS_EN defined: if out_ready is also 1, that word SHALL NOT be written to storage and count SHALL stay 0; if out_ready is 0, the word SHALL be pushed normally.
REQ-030 Without PIPE_STAGE_BYPASS_EN, REQ-018 and REQ-019 SHALL apply unchanged, and no combinational path SHALL exist from in_* to out_*.

Verification
REQ-031 Reset check: rst = 1 for 2 cycles, then released -> out_valid = 0, out_data = 32'h13, in_ready = 1, count = 0.
REQ-032 Fill/drain, DEPTH = 2: push 0xA1 then 0xA2 with out_ready = 0 -> count = 2, in_ready = 0; a third push 0xA3 is refused; then out_ready = 1 -> out_data = 0xA1 then 0xA2, then out_valid = 0.
REQ-033 Simultaneous push/pop at full: count = 2 holding 0xB1, 0xB2; push 0xB3 while popping (in_ready = 0) -> push refused, count = 1. With count = 1, push and pop in the same cycle -> count stays 1, order 0xB2 then 0xB3.
REQ-034 Wrap-around, DEPTH = 3: stream 10 words 0x1..0xA with random out_ready -> output order 0x1..0xA, no loss or duplicate.
REQ-035 Flush mid-operation: count = 2, assert flush together with in_valid (in_data 0xC1) -> next cycle count = 0, out_data = 32'h13; 0xC1 never appears on out_data.
REQ-036 Bypass, with PIPE_STAGE_BYPASS_EN defined: empty buffer, in_valid = 1 with in_data 0xD1, out_ready = 1 -> out_data = 0xD1 in the same cycle and count stays 0. Without the macro, 0xD1 appears one cycle later.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Flushable DEPTH-entry circular buffer between valid/ready pipeline stages; 1-cycle latency (0 when empty with PIPE_STAGE_BYPASS_EN).
// Backpressure: in_ready = not full and never looks at out_ready; flush drops everything, rst overrides all.
module pipe_stage_buf #(
    parameter int               WIDTH  = 32,
    parameter int               DEPTH  = 2,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(32'h0000_0013)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty, byp, push, pop, wr_en, rd_en;

    assign empty = (count_q == '0);

`ifdef PIPE_STAGE_BYPASS_EN
    assign byp = empty && in_valid && !flush;
`else
    assign byp = 1'b0;
`endif

    assign in_ready  = (count_q != FULL);
    assign out_valid = !empty || byp;
    assign count     = count_q;

    always_comb begin
        out_data = BUBBLE;
        if (byp) begin
            out_data = in_data;
        end else if (!empty) begin
            out_data = mem_q[rd_ptr_q];
        end
    end

    // A bypassed word consumed in the same cycle never touches storage.
    assign push  = in_valid && in_ready && !flush;
    assign pop   = out_valid && out_ready && !flush;
    assign wr_en = push && !(byp && out_ready);
    assign rd_en = pop && !byp;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count_d = count_q + 1'b1;
            end else if (rd_en && !wr_en) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is deliberately not reset; only pointers and count are.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: DEPTH=2 and DEPTH=3 instances share stimulus; a queue model per instance is compared every cycle.
module tb_pipe_stage_buf;

    localparam logic [31:0] BUB = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, out_ready;
    logic [31:0]       in_data;
    logic [1:0]        in_ready_v, out_valid_v;
    logic [1:0][31:0]  out_data_v;
    logic [1:0][1:0]   count_v;

    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;
    bit   log_en = 1'b0;
    logic [31:0] mq[2][$];
    logic [31:0] out_log[$];

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .BUBBLE(32'h13)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_v[0]), .out_valid(out_valid_v[0]), .out_data(out_data_v[0]),
        .out_ready(out_ready), .count(count_v[0])
    );

    pipe_stage_buf #(.WIDTH(32), .DEPTH(3), .BUBBLE(32'h13)) u_d3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_v[1]), .out_valid(out_valid_v[1]), .out_data(out_data_v[1]),
        .out_ready(out_ready), .count(count_v[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: a plain FIFO queue per instance; outputs derived from its size and head.
    always @(negedge clk) begin
        int          dep, sz;
        bit          byp, ev, er, pop, push;
        logic [31:0] ed;
        for (int k = 0; k < 2; k++) begin
            dep = k + 2;
            sz  = mq[k].size();
`ifdef PIPE_STAGE_BYPASS_EN
            byp = (sz == 0) && in_valid && !flush;
`else
            byp = 1'b0;
`endif
            ev = (sz != 0) || byp;
            ed = byp ? in_data : ((sz != 0) ? mq[k][0] : BUB);
            er = (sz != dep);
            if (chk_en) begin
                chk($sformatf("out_valid_d%0d", dep), {31'b0, out_valid_v[k]}, {31'b0, ev});
                chk($sformatf("out_data_d%0d", dep), out_data_v[k], ed);
                chk($sformatf("in_ready_d%0d", dep), {31'b0, in_ready_v[k]}, {31'b0, er});
                chk($sformatf("count_d%0d", dep), {30'b0, count_v[k]}, 32'(sz));
            end
            pop  = ev && out_ready && !flush;
            push = in_valid && er && !flush;
            if (rst || flush) begin
                mq[k].delete();
            end else begin
                if (log_en && k == 1 && pop) out_log.push_back(out_data_v[1]);
                if (!(byp && pop)) begin
                    if (pop) void'(mq[k].pop_front());
                    if (push) mq[k].push_back(in_data);
                end
            end
        end
    end

    initial begin
        int nxt, cyc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        #2;
        chk("rst_out_valid", {31'b0, out_valid_v[0]}, 32'd0);
        chk("rst_out_data", out_data_v[0], 32'h13);
        chk("rst_in_ready", {31'b0, in_ready_v[0]}, 32'd1);
        chk("rst_count", {30'b0, count_v[0]}, 32'd0);
        chk_en = 1'b1;

        // Fill to full, refuse a third push, then drain in order.
        in_valid = 1'b1; in_data = 32'hA1; step();
        in_data = 32'hA2; step();
        #2;
        chk("fill_count", {30'b0, count_v[0]}, 32'd2);
        chk("fill_in_ready", {31'b0, in_ready_v[0]}, 32'd0);
        in_data = 32'hA3; step();
        in_valid = 1'b0; out_ready = 1'b1;
        #2;
        chk("full_hold_count", {30'b0, count_v[0]}, 32'd2);
        chk("drain_first", out_data_v[0], 32'hA1);
        step(); #2;
        chk("drain_second", out_data_v[0], 32'hA2);
        step(); #2;
        chk("drain_empty_valid", {31'b0, out_valid_v[0]}, 32'd0);
        chk("drain_empty_data", out_data_v[0], 32'h13);
        out_ready = 1'b0;

        // Push refused at full while popping, then simultaneous push/pop at count 1.
        in_valid = 1'b1; in_data = 32'hB1; step();
        in_data = 32'hB2; step();
        in_data = 32'hB3; out_ready = 1'b1;
        #2;
        chk("full_pop_in_ready", {31'b0, in_ready_v[0]}, 32'd0);
        step(); #2;
        chk("refused_count", {30'b0, count_v[0]}, 32'd1);
        chk("refused_head", out_data_v[0], 32'hB2);
        step(); #2;
        chk("pushpop_count", {30'b0, count_v[0]}, 32'd1);
        chk("pushpop_head", out_data_v[0], 32'hB3);
        in_valid = 1'b0; step(); #2;
        chk("pushpop_drained", {31'b0, out_valid_v[0]}, 32'd0);
        out_ready = 1'b0;

        // Flush with a concurrent push.
        in_valid = 1'b1; in_data = 32'hE1; step();
        in_data = 32'hE2; step();
        flush = 1'b1; in_data = 32'hC1; step();
        flush = 1'b0; in_valid = 1'b0;
        #2;
        chk("flush_count", {30'b0, count_v[0]}, 32'd0);
        chk("flush_data", out_data_v[0], 32'h13);
        chk("flush_valid", {31'b0, out_valid_v[0]}, 32'd0);
        out_ready = 1'b1; step(); step();
        out_ready = 1'b0;

        // Empty buffer, push with downstream ready.
        in_valid = 1'b1; in_data = 32'hD1; out_ready = 1'b1;
        #2;
`ifdef PIPE_STAGE_BYPASS_EN
        chk("byp_valid", {31'b0, out_valid_v[0]}, 32'd1);
        chk("byp_data", out_data_v[0], 32'hD1);
        step(); in_valid = 1'b0; #2;
        chk("byp_count", {30'b0, count_v[0]}, 32'd0);
        chk("byp_after_valid", {31'b0, out_valid_v[0]}, 32'd0);
`else
        chk("nobyp_valid", {31'b0, out_valid_v[0]}, 32'd0);
        chk("nobyp_data", out_data_v[0], 32'h13);
        step(); in_valid = 1'b0; #2;
        chk("nobyp_count", {30'b0, count_v[0]}, 32'd1);
        chk("nobyp_late_data", out_data_v[0], 32'hD1);
        step(); #2;
        chk("nobyp_drained", {31'b0, out_valid_v[0]}, 32'd0);
`endif
        out_ready = 1'b0;

        // Ten-word stream through the DEPTH=3 instance with random stalls.
        log_en = 1'b1; nxt = 1; cyc = 0;
        while (nxt <= 10 && cyc < 300) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 32'(nxt);
            out_ready = 1'($urandom_range(0, 1));
            #2;
            if (in_valid && mq[1].size() != 3) nxt++;
            step();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
        while (mq[1].size() != 0 && cyc < 50) begin
            step();
            cyc++;
        end
        log_en = 1'b0;
        chk("stream_all_sent", 32'(nxt), 32'd11);
        chk("stream_log_size", 32'(out_log.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < out_log.size()) chk($sformatf("stream_order_%0d", i), out_log[i], 32'(i + 1));
        end

        // Fully random traffic with occasional flush and reset.
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step(); step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
